gdsp_ctrl_unit: RTL

GDSP_CTRL_UNIT -- requirements
Module: gdsp_ctrl_unit

---
 rtl/gdsp_ctrl_unit.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/gdsp_ctrl_unit.sv
// Control unit for the GDSP demo: symbol strobe, debounced user button (short press steps
// noise level, long press toggles bypass), noise magnitude and LEDs. Macro: GDSP_CTRL_STRETCH_EN.
`timescale 1ns/1ps
module gdsp_ctrl_unit #(
  parameter int SPS           = 4,
  parameter int NOISE_LEVELS  = 4,
  parameter int BASE_MAG      = 16,
  parameter int DEBOUNCE_CYC  = 270000,
  parameter int LONGPRESS_CYC = 27000000,
  parameter int HB_WIDTH      = 25,
  parameter int STRETCH_CYC   = 1350000
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            btn_user,
  input  logic                            shaped_valid,
  input  logic                            rx_valid,
  output logic                            sym_tick,
  output logic [7:0]                      noise_mag,
  output logic [$clog2(NOISE_LEVELS)-1:0] level_idx,
  output logic                            bypass,
  output logic [5:0]                      led
);
  localparam int LW  = $clog2(NOISE_LEVELS);
  localparam int SCW = $clog2(SPS);
  localparam int DCW = $clog2(DEBOUNCE_CYC + 1);
  localparam int HCW = $clog2(LONGPRESS_CYC + 1);
`ifdef GDSP_CTRL_STRETCH_EN
  localparam bit STRETCH_EN = 1'b1;
`else
  localparam bit STRETCH_EN = 1'b0;
`endif

  typedef enum logic [1:0] {S_IDLE, S_PRESS, S_HELD} state_t;

  logic [SCW-1:0]      r_sym_cnt;
  logic                r_sym_tick;
  logic                r_sync1, r_sync2, r_btn_db;
  logic [DCW-1:0]      r_db_cnt;
  state_t              r_state;
  logic [HCW-1:0]      r_hold;
  logic [LW-1:0]       r_level;
  logic                r_bypass;
  logic [7:0]          r_noise_mag;
  logic [HB_WIDTH-1:0] r_hb;
  logic [3:0]          r_led_st;
  logic [23:0]         w_shifted;
  logic [1:0]          w_strobe;
  logic [1:0]          w_act_n;
  logic                w_led5;

  // Tick lands in the same cycle the counter sits at SPS-1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sym_cnt  <= '0;
      r_sym_tick <= 1'b0;
    end else begin
      r_sym_cnt  <= (r_sym_cnt == SCW'(SPS - 1)) ? '0 : r_sym_cnt + SCW'(1);
      r_sym_tick <= (r_sym_cnt == SCW'(SPS - 2));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1  <= 1'b1;
      r_sync2  <= 1'b1;
      r_btn_db <= 1'b1;
      r_db_cnt <= '0;
    end else begin
      r_sync1 <= btn_user;
      r_sync2 <= r_sync1;
      if (r_sync2 == r_btn_db) begin
        r_db_cnt <= '0;
      end else if (r_db_cnt == DCW'(DEBOUNCE_CYC - 1)) begin
        r_btn_db <= r_sync2;
        r_db_cnt <= '0;
      end else begin
        r_db_cnt <= r_db_cnt + DCW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_hold   <= '0;
      r_level  <= '0;
      r_bypass <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (!r_btn_db) begin
            r_state <= S_PRESS;
            r_hold  <= '0;
          end
        end
        S_PRESS: begin
          if (r_btn_db) begin
            r_state <= S_IDLE;
            r_level <= (r_level == LW'(NOISE_LEVELS - 1)) ? '0 : r_level + LW'(1);
          end else if (r_hold == HCW'(LONGPRESS_CYC - 1)) begin
            r_state  <= S_HELD;
            r_hold   <= r_hold + HCW'(1);
            r_bypass <= ~r_bypass;
          end else begin
            r_hold <= r_hold + HCW'(1);
          end
        end
        S_HELD: begin
          if (r_btn_db) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Wide enough for an 8-bit base shifted by up to 15 levels, so saturation is exact.
  assign w_shifted = 24'(BASE_MAG) << r_level;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_noise_mag <= 8'(BASE_MAG);
      r_hb        <= '0;
      r_led_st    <= 4'b1011;
    end else begin
      r_noise_mag <= r_bypass ? 8'd0 : ((|w_shifted[23:8]) ? 8'hFF : w_shifted[7:0]);
      r_hb        <= r_hb + HB_WIDTH'(1);
      r_led_st    <= {w_led5, ~r_level[0], ~r_bypass, ~r_hb[HB_WIDTH-1]};
    end
  end

  generate
    if (LW >= 2) begin : g_led5_lvl
      assign w_led5 = ~r_level[1];
    end else begin : g_led5_off
      assign w_led5 = 1'b1;
    end
  endgenerate

  assign w_strobe = {rx_valid, shaped_valid};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_act
      logic r_act_n;
      if (STRETCH_EN) begin : g_stretch
        localparam int TCW = $clog2(STRETCH_CYC + 1);
        logic [TCW-1:0] r_cnt;
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            r_cnt   <= '0;
            r_act_n <= 1'b1;
          end else if (w_strobe[gi]) begin
            r_cnt   <= TCW'(STRETCH_CYC - 1);
            r_act_n <= 1'b0;
          end else if (r_cnt != '0) begin
            r_cnt   <= r_cnt - TCW'(1);
            r_act_n <= 1'b0;
          end else begin
            r_act_n <= 1'b1;
          end
        end
      end else begin : g_raw
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) r_act_n <= 1'b1;
          else        r_act_n <= ~w_strobe[gi];
        end
      end
      assign w_act_n[gi] = r_act_n;
    end
  endgenerate

  assign sym_tick  = r_sym_tick;
  assign noise_mag = r_noise_mag;
  assign level_idx = r_level;
  assign bypass    = r_bypass;
  assign led       = {r_led_st[3:2], w_act_n, r_led_st[1:0]};
endmodule
